// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants and state encoding for the pipeline sequencer and its
// hazard detector.
package pipeline_sequencer_pkg;

   // Bubble encoding: class 11, op 1110, no side effects.
   localparam logic [15:0] NOP_WORD_DEFAULT = 16'hC0E0;

   // Opcode classes held in instruction bits [15:14].
   localparam logic [1:0] CLS_LD  = 2'b00;
   localparam logic [1:0] CLS_ST  = 2'b01;
   localparam logic [1:0] CLS_ALU = 2'b11;

   // Branch prefixes held in instruction bits [15:11].
   localparam logic [4:0] BR_UNCOND = 5'b10100;
   localparam logic [4:0] BR_COND   = 5'b10111;

   // HLT is an ALU-class instruction with op field [7:4] = 1111.
   localparam logic [3:0] HLT_OP = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_SQUASH = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALT   = 3'd4
   } seq_state_t;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Purely combinational decode of the ID/EX history: load-use hazard,
// HLT in ID and branch in EX. Gating by sequencer state happens in the top.
module pipe_hazard_detect
   import pipeline_sequencer_pkg::*;
(
   input  logic [15:0] command,
   input  logic [15:0] before_command,
   output logic        hazard_stall,
   output logic        is_hlt,
   output logic        is_branch
);

   logic [2:0] dest;
   logic       reads_src_a;
   logic       reads_src_b;

   // A load in EX collides with any ID instruction that reads its destination.
   always_comb begin
      dest        = before_command[13:11];
      reads_src_a = (command[10:8] == dest) &&
                    ((command[15:14] == CLS_LD) ||
                     (command[15:14] == CLS_ST) ||
                     (command[15:14] == CLS_ALU));
      reads_src_b = (command[15:14] == CLS_ALU) && (command[13:11] == dest);
      hazard_stall = (before_command[15:14] == CLS_LD) && (reads_src_a || reads_src_b);
      is_hlt       = (command[15:14] == CLS_ALU) && (command[7:4] == HLT_OP);
      is_branch    = (before_command[15:11] == BR_UNCOND) ||
                     (before_command[15:11] == BR_COND);
   end

endmodule

// File: rtl/pipeline_sequencer.sv
// Three-deep instruction history (ID/EX/WB) with start/halt control,
// load-use bubble insertion and wrong-path squashing after taken branches.
module pipeline_sequencer
   import pipeline_sequencer_pkg::*;
#(
   parameter int unsigned FETCH_LAT = 1,
   parameter int unsigned CNT_W     = 16,
   parameter logic [15:0] NOP_WORD  = NOP_WORD_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             ext_stall,
   input  logic [15:0]      fetch_word,
   input  logic             branch_taken,
   output logic             pc_enable,
   output logic [15:0]      command,
   output logic [15:0]      before_command,
   output logic [15:0]      two_before_command,
   output logic             hazard_stall,
   output logic             running,
   output logic             halted,
   output logic [CNT_W-1:0] bubble_count
);

   localparam logic [1:0] SQUASH_INIT = 2'(FETCH_LAT);

   seq_state_t       state_reg, state_next;
   logic [15:0]      cmd_reg, cmd_next;
   logic [15:0]      bef_reg, bef_next;
   logic [15:0]      two_reg, two_next;
   logic [1:0]       squash_reg, squash_next;
   logic             drain_reg, drain_next;
   logic [CNT_W-1:0] bub_reg, bub_next;
   logic             bubble;
   logic             raw_hazard;
   logic             is_hlt;
   logic             is_branch;

   pipe_hazard_detect u_hazard (
      .command        (cmd_reg),
      .before_command (bef_reg),
      .hazard_stall   (raw_hazard),
      .is_hlt         (is_hlt),
      .is_branch      (is_branch)
   );

   // Next-state and output decode; ext_stall freezes everything.
   always_comb begin
      state_next   = state_reg;
      cmd_next     = cmd_reg;
      bef_next     = bef_reg;
      two_next     = two_reg;
      squash_next  = squash_reg;
      drain_next   = drain_reg;
      pc_enable    = 1'b0;
      hazard_stall = 1'b0;
      bubble       = 1'b0;
      if (!ext_stall) begin
         case (state_reg)
            ST_IDLE, ST_HALT: begin
               if (start) state_next = ST_RUN;
            end
            ST_RUN: begin
               if (is_branch && branch_taken) begin
                  // Both younger slots are wrong-path; the PC unit loads the target.
                  two_next  = bef_reg;
                  bef_next  = NOP_WORD;
                  cmd_next  = NOP_WORD;
                  pc_enable = 1'b1;
                  bubble    = 1'b1;
                  if (FETCH_LAT > 0) begin
                     squash_next = SQUASH_INIT;
                     state_next  = ST_SQUASH;
                  end
               end else if (raw_hazard) begin
                  // Hold ID and slip a bubble into EX for one cycle.
                  hazard_stall = 1'b1;
                  two_next     = bef_reg;
                  bef_next     = NOP_WORD;
                  bubble       = 1'b1;
               end else if (is_hlt) begin
                  // HLT moves on to EX; nothing new is fetched behind it.
                  two_next   = bef_reg;
                  bef_next   = cmd_reg;
                  cmd_next   = NOP_WORD;
                  drain_next = 1'b0;
                  state_next = ST_DRAIN;
               end else begin
                  two_next  = bef_reg;
                  bef_next  = cmd_reg;
                  cmd_next  = fetch_word;
                  pc_enable = 1'b1;
               end
            end
            ST_SQUASH: begin
               // Words fetched before the redirect are discarded.
               two_next    = bef_reg;
               bef_next    = cmd_reg;
               cmd_next    = NOP_WORD;
               pc_enable   = 1'b1;
               bubble      = 1'b1;
               squash_next = squash_reg - 2'd1;
               if (squash_reg <= 2'd1) state_next = ST_RUN;
            end
            ST_DRAIN: begin
               // Two more shifts push HLT out of WB.
               two_next   = bef_reg;
               bef_next   = cmd_reg;
               cmd_next   = NOP_WORD;
               drain_next = 1'b1;
               if (drain_reg) state_next = ST_HALT;
            end
            default: state_next = ST_IDLE;
         endcase
      end
      bub_next = (bubble && (bub_reg != {CNT_W{1'b1}})) ? bub_reg + 1'b1 : bub_reg;
   end

   // State and history registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         cmd_reg    <= NOP_WORD;
         bef_reg    <= NOP_WORD;
         two_reg    <= NOP_WORD;
         squash_reg <= 2'd0;
         drain_reg  <= 1'b0;
         bub_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         cmd_reg    <= cmd_next;
         bef_reg    <= bef_next;
         two_reg    <= two_next;
         squash_reg <= squash_next;
         drain_reg  <= drain_next;
         bub_reg    <= bub_next;
      end
   end

   // Status outputs decoded from state.
   always_comb begin
      running            = (state_reg == ST_RUN) || (state_reg == ST_SQUASH) ||
                           (state_reg == ST_DRAIN);
      halted             = (state_reg == ST_HALT);
      command            = cmd_reg;
      before_command     = bef_reg;
      two_before_command = two_reg;
      bubble_count       = bub_reg;
   end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench: stimulus drives inputs and pushes the expected response
// from a behavioural model; an independent monitor pops and compares.
module tb_pipeline_sequencer;

   localparam int FETCH_LAT = 1;
   localparam int CNT_W     = 6;
   localparam int CNT_MAX   = 63;
   localparam logic [15:0] NOP = 16'hC0E0;

   localparam int M_IDLE = 0, M_RUN = 1, M_SQUASH = 2, M_DRAIN = 3, M_HALT = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start = 1'b0;
   logic             ext_stall = 1'b0;
   logic [15:0]      fetch_word = 16'h0000;
   logic             branch_taken = 1'b0;
   logic             pc_enable;
   logic [15:0]      command;
   logic [15:0]      before_command;
   logic [15:0]      two_before_command;
   logic             hazard_stall;
   logic             running;
   logic             halted;
   logic [CNT_W-1:0] bubble_count;

   pipeline_sequencer #(.FETCH_LAT(FETCH_LAT), .CNT_W(CNT_W)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .ext_stall          (ext_stall),
      .fetch_word         (fetch_word),
      .branch_taken       (branch_taken),
      .pc_enable          (pc_enable),
      .command            (command),
      .before_command     (before_command),
      .two_before_command (two_before_command),
      .hazard_stall       (hazard_stall),
      .running            (running),
      .halted             (halted),
      .bubble_count       (bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        pc;
      logic        hz;
      logic        run;
      logic        hlt;
      logic [15:0] c;
      logic [15:0] b;
      logic [15:0] t;
      logic [5:0]  cnt;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   txn   = 0;

   // Behavioural model: hist[0]=ID, hist[1]=EX, hist[2]=WB.
   int          mode;
   logic [15:0] hist [3];
   int          sq_left;
   int          drain_left;
   int          m_cnt;

   function automatic bit load_use(input logic [15:0] ex, input logic [15:0] id);
      logic [2:0] d;
      d = ex[13:11];
      if (ex[15:14] != 2'b00) return 1'b0;
      if (id[15:14] != 2'b10 && id[10:8] == d) return 1'b1;
      if (id[15:14] == 2'b11 && id[13:11] == d) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      case ($urandom_range(0, 11))
         0, 1, 2: w = {2'b00, 3'($urandom_range(0, 2)), 11'($urandom)};
         3:       w = {2'b01, 3'($urandom), 3'($urandom_range(0, 2)), 8'($urandom)};
         4, 5, 6: w = {2'b11, 3'($urandom_range(0, 2)), 3'($urandom_range(0, 2)),
                      4'($urandom_range(0, 14)), 4'($urandom)};
         7:       w = {5'b10100, 11'($urandom)};
         8:       w = {5'b10111, 11'($urandom)};
         9:       w = ($urandom_range(0, 3) == 0) ? 16'hC0F0 : 16'hC1A5;
         default: w = 16'($urandom);
      endcase
      return w;
   endfunction

   task automatic model_init();
      mode = M_IDLE;
      hist[0] = NOP; hist[1] = NOP; hist[2] = NOP;
      sq_left = 0; drain_left = 0; m_cnt = 0;
   endtask

   task automatic shift_in(input logic [15:0] w);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = w;
   endtask

   task automatic bump();
      if (m_cnt < CNT_MAX) m_cnt++;
   endtask

   // One clock of stimulus: drive, predict this cycle's outputs, advance model.
   task automatic step(input logic st, input logic xs, input logic [15:0] fw, input logic bt);
      exp_t e;
      bit   br, hz, hl;
      @(negedge clk);
      start = st; ext_stall = xs; fetch_word = fw; branch_taken = bt;
      br = 0; hz = 0; hl = 0;
      if (!xs && mode == M_RUN) begin
         if ((hist[1][15:11] == 5'b10100 || hist[1][15:11] == 5'b10111) && bt) br = 1;
         else if (load_use(hist[1], hist[0])) hz = 1;
         else if (hist[0][15:14] == 2'b11 && hist[0][7:4] == 4'hF) hl = 1;
      end
      e.pc  = !xs && ((mode == M_RUN && !hz && !hl) || mode == M_SQUASH);
      e.hz  = hz;
      e.run = (mode == M_RUN || mode == M_SQUASH || mode == M_DRAIN);
      e.hlt = (mode == M_HALT);
      e.c   = hist[0];
      e.b   = hist[1];
      e.t   = hist[2];
      e.cnt = 6'(m_cnt);
      q.push_back(e);
      if (!xs) begin
         case (mode)
            M_IDLE, M_HALT: if (st) mode = M_RUN;
            M_RUN: begin
               if (br) begin
                  hist[2] = hist[1]; hist[1] = NOP; hist[0] = NOP;
                  bump();
                  sq_left = FETCH_LAT;
                  if (sq_left > 0) mode = M_SQUASH;
               end else if (hz) begin
                  hist[2] = hist[1]; hist[1] = NOP;
                  bump();
               end else if (hl) begin
                  shift_in(NOP);
                  drain_left = 2;
                  mode = M_DRAIN;
               end else begin
                  shift_in(fw);
               end
            end
            M_SQUASH: begin
               shift_in(NOP);
               bump();
               sq_left--;
               if (sq_left == 0) mode = M_RUN;
            end
            M_DRAIN: begin
               shift_in(NOP);
               drain_left--;
               if (drain_left == 0) mode = M_HALT;
            end
            default: mode = M_IDLE;
         endcase
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; start = 1'b0; ext_stall = 1'b0; branch_taken = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_init();
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL txn %0d %s: got %h expected %h", txn, name, act, exp);
      end
   endtask

   // Monitor: compares DUT outputs against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            txn++;
            check("pc_enable", 16'(pc_enable), 16'(e.pc));
            check("hazard_stall", 16'(hazard_stall), 16'(e.hz));
            check("running", 16'(running), 16'(e.run));
            check("halted", 16'(halted), 16'(e.hlt));
            check("command", command, e.c);
            check("before_command", before_command, e.b);
            check("two_before_command", two_before_command, e.t);
            check("bubble_count", 16'(bubble_count), 16'(e.cnt));
            $display("[TB] txn %0d cmd=%h bef=%h two=%h pc=%b hz=%b run=%b hlt=%b cnt=%0d",
                     txn, command, before_command, two_before_command,
                     pc_enable, hazard_stall, running, halted, bubble_count);
         end
      end
   end

   initial begin
      logic st, xs, bt;
      model_init();
      do_reset();
      // Reset state, then straight-line fetch.
      step(0, 0, 16'h1234, 0);
      step(1, 0, 16'h0000, 0);
      step(0, 0, 16'hC100, 0);
      step(0, 0, 16'hC200, 0);
      step(0, 0, 16'hC300, 0);
      // Load-use: LD r1 then ADD reading r1.
      step(0, 0, 16'h0900, 0);
      step(0, 0, 16'hC100, 0);
      step(0, 0, 16'hC100, 0);
      step(0, 0, 16'hC200, 0);
      // Taken branch with a stall held mid-squash.
      step(0, 0, 16'hA000, 1);
      step(0, 0, 16'hC400, 1);
      step(0, 0, 16'hC500, 1);
      step(0, 1, 16'hDEAD, 1);
      step(0, 1, 16'hDEAD, 1);
      step(0, 1, 16'hDEAD, 1);
      step(0, 0, 16'hC600, 1);
      step(0, 0, 16'hC700, 0);
      // HLT drains to HALT, then restart.
      step(0, 0, 16'hC0F0, 0);
      step(0, 0, 16'hC800, 0);
      step(0, 0, 16'hC800, 0);
      step(0, 0, 16'hC800, 0);
      step(0, 0, 16'hC800, 0);
      step(1, 0, 16'hC800, 0);
      step(0, 0, 16'hC900, 0);
      step(0, 0, 16'hCA00, 0);
      // Randomised traffic; bubble_count saturates along the way.
      for (int i = 0; i < 1500; i++) begin
         xs = ($urandom_range(0, 7) == 0);
         if (mode == M_IDLE || mode == M_HALT) st = ($urandom_range(0, 2) == 0);
         else st = ($urandom_range(0, 19) == 0);
         bt = (hist[1][15:11] == 5'b10100) ? 1'b1 : 1'($urandom_range(0, 1));
         step(st, xs, rand_word(), bt);
      end
      // Reset taken while squashing.
      do_reset();
      step(1, 0, 16'h0000, 0);
      step(0, 0, 16'hA000, 1);
      step(0, 0, 16'hC100, 1);
      step(0, 0, 16'hC200, 1);
      do_reset();
      step(0, 0, 16'hC300, 0);
      // Reset taken while draining.
      step(1, 0, 16'h0000, 0);
      step(0, 0, 16'hC0F0, 0);
      step(0, 0, 16'hC100, 0);
      step(0, 0, 16'hC100, 0);
      do_reset();
      step(0, 0, 16'hC300, 0);
      step(0, 0, 16'hC300, 0);
      @(negedge clk);
      #3;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
